// File: rtl/rf_wren_guard.sv
// Write-enable integrity guard: glitch-free clock gate, protected strobe buffer and
// a combinational plus sticky check that exactly the addressed word strobe is set.

module rf_wren_guard_buf #(
   parameter int unsigned Width = 32
) (
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   assign q = d;

endmodule

module rf_wren_guard #(
   parameter  int unsigned AddrWidth   = 5,
   parameter  bit          AddrCheck   = 1'b1,
   parameter  bit          EnableCheck = 1'b1,
   localparam int unsigned OneHotWidth = 2 ** AddrWidth
) (
   input  logic                   clk_int,
   input  logic                   rst_ni,
   input  logic                   test_en_i,
   input  logic                   en_i,
   input  logic [AddrWidth-1:0]   addr_i,
   input  logic [OneHotWidth-1:0] oh_i,
   output logic                   clk_o,
   output logic [OneHotWidth-1:0] oh_buf_o,
   output logic                   err_o,
   output logic                   err_sticky_o
);

   logic                   en_lat;
   logic [OneHotWidth-1:0] addr_oh;
   logic                   multi_hot;
   logic                   en_off;
   logic                   addr_err;
   logic                   en_err;

   // NOTE: this latch is intentional; it is only transparent in the low phase, so the
   // enable cannot change while clk_int is high and clk_o never glitches or truncates.
   always_latch begin
      if (!clk_int) begin
         en_lat <= en_i | test_en_i;
      end
   end

   assign clk_o = clk_int & en_lat;

   // Separate kept instance so the checker cannot be folded back into the decoder.
   (* keep = "true", dont_touch = "true" *)
   rf_wren_guard_buf #(
      .Width (OneHotWidth)
   ) u_oh_buf (
      .d (oh_i),
      .q (oh_buf_o)
   );

   assign addr_oh   = OneHotWidth'(1) << addr_i;
   assign multi_hot = |(oh_buf_o & (oh_buf_o - OneHotWidth'(1)));
   assign en_off    = !en_i && (|oh_buf_o);
   assign addr_err  = AddrCheck && (|(oh_buf_o & ~addr_oh));
   assign en_err    = EnableCheck && en_i && !oh_buf_o[addr_i];

   assign err_o = multi_hot | en_off | addr_err | en_err;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         err_sticky_o <= 1'b0;
      end else if (err_o) begin
         err_sticky_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_wren_guard.sv
// Directed bench for rf_wren_guard: default-parameter DUT plus a checks-relaxed DUT
// sharing the same stimulus.

module tb_rf_wren_guard;

   localparam int unsigned AW = 5;
   localparam int unsigned OW = 32;

   logic          clk_int = 1'b0;
   logic          rst_ni;
   logic          test_en_i;
   logic          en_i;
   logic [AW-1:0] addr_i;
   logic [OW-1:0] oh_i;

   logic          clk_o_0, clk_o_1;
   logic [OW-1:0] oh_buf_0, oh_buf_1;
   logic          err_0, err_1;
   logic          sticky_0, sticky_1;

   int total = 0;
   int bad   = 0;

   always #5 clk_int = ~clk_int;

   rf_wren_guard u_dut (
      .clk_int      (clk_int),
      .rst_ni       (rst_ni),
      .test_en_i    (test_en_i),
      .en_i         (en_i),
      .addr_i       (addr_i),
      .oh_i         (oh_i),
      .clk_o        (clk_o_0),
      .oh_buf_o     (oh_buf_0),
      .err_o        (err_0),
      .err_sticky_o (sticky_0)
   );

   rf_wren_guard #(
      .AddrWidth   (AW),
      .AddrCheck   (1'b0),
      .EnableCheck (1'b0)
   ) u_dut_nochk (
      .clk_int      (clk_int),
      .rst_ni       (rst_ni),
      .test_en_i    (test_en_i),
      .en_i         (en_i),
      .addr_i       (addr_i),
      .oh_i         (oh_i),
      .clk_o        (clk_o_1),
      .oh_buf_o     (oh_buf_1),
      .err_o        (err_1),
      .err_sticky_o (sticky_1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive inputs in the low phase, then let combinational outputs settle.
   task automatic drive(input logic en, input logic [AW-1:0] addr, input logic [OW-1:0] oh);
      @(negedge clk_int);
      en_i   = en;
      addr_i = addr;
      oh_i   = oh;
      #1;
   endtask

   initial begin
      rst_ni    = 1'b0;
      test_en_i = 1'b0;
      en_i      = 1'b0;
      addr_i    = '0;
      oh_i      = '0;
      #2;
      check("reset_sticky", 32'(sticky_0), 32'd0);
      check("reset_err", 32'(err_0), 32'd0);
      check("reset_clk_o", 32'(clk_o_0), 32'd0);
      @(negedge clk_int);
      rst_ni = 1'b1;

      // Legal write to word 5: no error, buffer mirrors, clock pulses.
      drive(1'b1, 5'd5, 32'h20);
      check("legal5_err", 32'(err_0), 32'd0);
      check("legal5_buf", oh_buf_0, 32'h20);
      @(posedge clk_int); #2;
      check("legal5_clk_o_high", 32'(clk_o_0), 32'd1);
      check("legal5_sticky", 32'(sticky_0), 32'd0);

      // Legal writes across the address range, including both ends.
      drive(1'b1, 5'd0, 32'h1);
      check("legal0_err", 32'(err_0), 32'd0);
      drive(1'b1, 5'd31, 32'h8000_0000);
      check("legal31_err", 32'(err_0), 32'd0);
      check("legal31_buf", oh_buf_0, 32'h8000_0000);

      // Idle: gate stays closed for three cycles.
      drive(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_int); #2;
         check("idle_clk_o", 32'(clk_o_0), 32'd0);
         check("idle_err", 32'(err_0), 32'd0);
      end

      // Test enable forces the gate open.
      @(negedge clk_int);
      test_en_i = 1'b1;
      @(posedge clk_int); #2;
      check("test_en_clk_o_high", 32'(clk_o_0), 32'd1);
      @(negedge clk_int); #2;
      check("test_en_clk_o_low", 32'(clk_o_0), 32'd0);
      test_en_i = 1'b0;
      check("sticky_still_clear", 32'(sticky_0), 32'd0);

      // Multi-hot: combinational error now, sticky after the edge, held afterwards.
      drive(1'b1, 5'd5, 32'h24);
      check("multihot_err", 32'(err_0), 32'd1);
      check("multihot_err_nochk", 32'(err_1), 32'd1);
      check("multihot_sticky_pre", 32'(sticky_0), 32'd0);
      @(posedge clk_int); #2;
      check("multihot_sticky_set", 32'(sticky_0), 32'd1);
      drive(1'b1, 5'd5, 32'h20);
      check("fixed_err", 32'(err_0), 32'd0);
      @(posedge clk_int); #2;
      check("sticky_holds", 32'(sticky_0), 32'd1);

      // Asynchronous reset mid-cycle clears sticky immediately.
      rst_ni = 1'b0;
      #1;
      check("async_rst_sticky", 32'(sticky_0), 32'd0);
      @(negedge clk_int);
      rst_ni = 1'b1;

      // Misaddressed single strobe.
      drive(1'b1, 5'd5, 32'h10);
      check("misaddr_err", 32'(err_0), 32'd1);
      check("misaddr_err_nochk", 32'(err_1), 32'd0);

      // Strobe with enable low is always an error.
      drive(1'b0, 5'd0, 32'h01);
      check("enoff_err", 32'(err_0), 32'd1);
      check("enoff_err_nochk", 32'(err_1), 32'd1);

      // Missing strobe with enable high.
      drive(1'b1, 5'd3, 32'h0);
      check("missing_err", 32'(err_0), 32'd1);
      check("missing_err_nochk", 32'(err_1), 32'd0);

      // Enable drop during the high phase must not truncate the pulse.
      drive(1'b1, 5'd3, 32'h08);
      @(posedge clk_int); #1;
      check("glitch_pulse_start", 32'(clk_o_0), 32'd1);
      en_i = 1'b0;
      #1;
      check("glitch_no_truncate", 32'(clk_o_0), 32'd1);
      @(posedge clk_int); #1;
      check("glitch_gate_closed", 32'(clk_o_0), 32'd0);
      // Enable rise during the high phase must not create a partial pulse.
      en_i = 1'b1;
      #1;
      check("glitch_no_runt", 32'(clk_o_0), 32'd0);
      @(posedge clk_int); #1;
      check("glitch_next_pulse", 32'(clk_o_0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
